// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the majority-vote helper used at mid-bit.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OS_RATE   = 16;
    localparam int VOTE_T0   = 7;
    localparam int VOTE_T1   = 8;
    localparam int VOTE_T2   = 9;
    localparam int LAST_TICK = 15;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-side bundle: serial line and divisor in, decoded word, strobe
// and status flags out.
interface uart_rx_os_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 11
);
    logic              rx_i;
    logic [DIV_W-1:0]  br_div;
    logic [DATA_W-1:0] dout;
    logic              rx_done;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  rx_i, br_div,
        output dout, rx_done, parity_err, frame_err, busy
    );

    modport master (
        output rx_i, br_div,
        input  dout, rx_done, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every br_div+1 clocks, divisor latched
// and phase reset on clear. Shared between the receive and transmit paths.
module uart_baud_tick #(
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] br_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // Divisor is only captured on clear so a frame keeps one bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (clear) begin
            div_q <= br_div;
            cnt   <= '0;
        end else if (cnt == div_q) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == div_q);

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and drive parity_err.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 11
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_os_if.slave  bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              sync1;
    logic              sync2;
    logic              line_prev;
    logic              fall;
    logic              tick;
    logic              clear;
    logic              vote;
    logic              at_vote;
    logic              at_end;

    rx_state_t         state;
    logic [3:0]        samp;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] dout_q;
    logic              v0;
    logic              v1;
    logic              rx_done_q;
    logic              frame_q;
    logic              busy_q;
`ifdef UART_RX_PARITY_EN
    logic              perr_q;
    logic              parity_q;
`endif

    // Edge detector needs the line seen high first, so a held break cannot
    // retrigger a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= bus.rx_i;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall  = line_prev & ~sync2;
    assign clear = (state == IDLE) && fall;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .br_div (bus.br_div),
        .tick   (tick)
    );

    assign vote    = maj3(v0, v1, sync2);
    assign at_vote = tick && (samp == 4'(VOTE_T2));
    assign at_end  = tick && (samp == 4'(LAST_TICK));

    // Frame FSM; the stop bit is resolved at mid-bit so the next start edge
    // can arrive right at the end of the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            samp      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            v0        <= 1'b1;
            v1        <= 1'b1;
            dout_q    <= '0;
            rx_done_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            if (clear) begin
                samp <= '0;
            end else if (tick) begin
                samp <= samp + 4'd1;
            end
            if (tick && (samp == 4'(VOTE_T0))) begin
                v0 <= sync2;
            end
            if (tick && (samp == 4'(VOTE_T1))) begin
                v1 <= sync2;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_vote) begin
                        shreg <= {vote, shreg[DATA_W-1:1]};
                    end
                    if (at_end) begin
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (at_vote) begin
                        perr_q <= (^shreg) ^ vote;
                    end
                    if (at_end) begin
                        state <= STOP;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (at_vote) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        rx_done_q <= 1'b1;
                        dout_q    <= shreg;
                        frame_q   <= ~vote;
`ifdef UART_RX_PARITY_EN
                        parity_q  <= perr_q;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are described at bit level and a
// queue of expected words is checked against every rx_done and every cycle.
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int DIVV   = 3;
    localparam int BIT_T  = 16 * (DIVV + 1);
    localparam int NBITS  = 10 + PAR_EN;
    localparam int LAT    = 3 + 16 * (DIVV + 1) * (NBITS - 1) + 10 * (DIVV + 1);

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         start_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   assert_count;
    int   fail_count;
    int   last_latency;
    exp_t exp_q[$];
    logic [7:0] m_dout;
    logic       m_pe;
    logic       m_fe;

    uart_rx_os_if #(.DATA_W(8), .DIV_W(11)) bus ();

    uart_rx_os #(.DATA_W(8), .DIV_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        bus.rx_i = b;
        repeat (n) @(negedge clk);
    endtask

    // Sends one complete frame and records what the receiver must report.
    task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stop);
        exp_t e;
        e.data      = data;
        e.perr      = (PAR_EN != 0) ? ((^data) ^ par) : 1'b0;
        e.ferr      = ~stop;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_T);
        if (PAR_EN != 0) drive_bit(par, BIT_T);
        drive_bit(stop, BIT_T);
        check_output("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Reference model: outputs hold the last expected frame until the next one.
    initial begin
        exp_t e;
        m_dout = '0;
        m_pe   = 1'b0;
        m_fe   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_dout = '0;
                m_pe   = 1'b0;
                m_fe   = 1'b0;
            end else begin
                if (bus.rx_done) begin
                    if (exp_q.size() == 0) begin
                        check_output("spurious_rx_done", 32'(bus.rx_done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        last_latency = cyc - e.start_cyc;
                        check_output("done_latency", 32'(last_latency), 32'(LAT));
                        m_dout = e.data;
                        m_pe   = e.perr;
                        m_fe   = e.ferr;
                    end
                end
                check_output("dout", 32'(bus.dout), 32'(m_dout));
                check_output("parity_err", 32'(bus.parity_err), 32'(m_pe));
                check_output("frame_err", 32'(bus.frame_err), 32'(m_fe));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got %0d cycles", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cyc          = 0;
        assert_count = 0;
        fail_count   = 0;
        last_latency = 0;
        rst          = 1'b0;
        bus.rx_i     = 1'b1;
        bus.br_div   = 11'(DIVV);
        repeat (5) @(negedge clk);
        check_output("reset_dout", 32'(bus.dout), 32'd0);
        check_output("reset_rx_done", 32'(bus.rx_done), 32'd0);
        check_output("reset_perr", 32'(bus.parity_err), 32'd0);
        check_output("reset_ferr", 32'(bus.frame_err), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Clean frame; also pins the absolute latency.
        apply_stimulus(8'hA5, ^8'hA5, 1'b1);
        check_output("a5_dout", 32'(bus.dout), 32'h0A5);
        check_output("a5_latency", 32'(last_latency), (PAR_EN != 0) ? 32'd683 : 32'd619);
        check_output("a5_busy_after", 32'(bus.busy), 32'd0);
        repeat (30) @(negedge clk);

        // Short glitch is a false start.
        drive_bit(1'b0, 20);
        check_output("glitch_busy_high", 32'(bus.busy), 32'd1);
        drive_bit(1'b1, 60);
        check_output("glitch_busy_low", 32'(bus.busy), 32'd0);
        check_output("glitch_dout_kept", 32'(bus.dout), 32'h0A5);

        // Wrong parity bit, then a clean frame clears the flag.
        apply_stimulus(8'h03, 1'b1, 1'b1);
        check_output("p03_perr", 32'(bus.parity_err), 32'(PAR_EN));
        check_output("p03_dout", 32'(bus.dout), 32'h003);
        repeat (10) @(negedge clk);
        apply_stimulus(8'h00, 1'b0, 1'b1);
        check_output("p00_perr_cleared", 32'(bus.parity_err), 32'd0);

        // Bad stop bit followed by a break, then recovery.
        apply_stimulus(8'h5A, ^8'h5A, 1'b0);
        drive_bit(1'b0, 200);
        check_output("break_ferr", 32'(bus.frame_err), 32'd1);
        check_output("break_busy", 32'(bus.busy), 32'd0);
        drive_bit(1'b1, BIT_T);
        apply_stimulus(8'h3C, ^8'h3C, 1'b1);
        check_output("after_break_dout", 32'(bus.dout), 32'h03C);
        check_output("after_break_ferr", 32'(bus.frame_err), 32'd0);

        // Back-to-back frames with no idle time between them.
        apply_stimulus(8'h11, ^8'h11, 1'b1);
        apply_stimulus(8'h22, ^8'h22, 1'b1);
        check_output("b2b_dout", 32'(bus.dout), 32'h022);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 4 discards the partial frame.
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ (i != 0), BIT_T);
        drive_bit(1'b1, BIT_T / 2);
        check_output("midframe_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check_output("rst_dout", 32'(bus.dout), 32'd0);
        check_output("rst_rx_done", 32'(bus.rx_done), 32'd0);
        check_output("rst_perr", 32'(bus.parity_err), 32'd0);
        check_output("rst_ferr", 32'(bus.frame_err), 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        drive_bit(1'b1, 10);
        rst = 1'b1;
        drive_bit(1'b1, 70);
        apply_stimulus(8'h7E, ^8'h7E, 1'b1);
        check_output("post_rst_dout", 32'(bus.dout), 32'h07E);

        // Plain 0xC3 frame; parity flag must stay clear.
        apply_stimulus(8'hC3, ^8'hC3, 1'b1);
        check_output("c3_dout", 32'(bus.dout), 32'h0C3);
        check_output("c3_perr", 32'(bus.parity_err), 32'd0);
        repeat (40) @(negedge clk);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver. It recovers the framed serial stream (start, DATA_W data bits LSB first, optional even parity, one stop) that the UART transmit path produces. Decoded words are presented to the local logic with a one-cycle done strobe and error flags. It is the receive end of the UART system and pairs with the existing transmitter in the UART top level.

## Interface
- DATA_W, 8: data bits per frame.
- DIV_W, 11: width of the baud divisor.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- br_div  in  DIV_W  oversample divisor; a 16x tick occurs every br_div+1 clocks, so bit time = 16*(br_div+1) clocks.
- rx_i  in  1  serial line, asynchronous, idle high.
- dout  out  DATA_W  last received word.
- rx_done  out  1  one-clock pulse when a frame completes.
- parity_err  out  1  parity mismatch on last frame.
- frame_err  out  1  stop bit sampled low on last frame.
- busy  out  1  high from start detection until frame completion.

## Operation
- rx_i passes through a 2-flop synchronizer (reset to 1), then a falling-edge detector.
- Tick generator:
  - Counts 0..br_div_q and pulses tick at the terminal value.
  - br_div_q is latched from br_div at start detection; br_div changes mid-frame are ignored.
  - Counter and 4-bit sample counter clear at start detection.
- Sampling: each bit is the majority vote of the synced line at ticks 7, 8 and 9 within the bit; the vote is final at tick 9.
- State machine:
  - IDLE: wait for a synced falling edge. On the edge, go to START and set busy.
  - START: after the vote, a result of 1 is a false start; return to IDLE with busy=0 and no flags touched. Otherwise, at tick 15 go to DATA.
  - DATA: shift in DATA_W bits, LSB first. After the last bit go to PARITY (if compiled in), else STOP.
  - PARITY: expected even parity; perr = ^data ^ vote.
  - STOP: at vote completion (mid stop bit), return to IDLE immediately and update the outputs:
    - dout=data
    - frame_err=~vote
    - parity_err=perr
    - rx_done=1 for one clock
    - busy=0
- Early return at mid-stop lets back-to-back frames be received.
- Error flags hold until the next completed frame; they are not sticky across frames.
- Line held low (break): the frame completes with frame_err=1. No new start is accepted until the synced line has been seen high, because the edge detector requires 1 then 0.

## Timing
- Reset values: dout=0, rx_done=0, parity_err=0, frame_err=0, busy=0, state=IDLE, synchronizer=1.
- Reset asserted mid-frame: all of the above take effect immediately; the partial frame is discarded.
- Start detection: 3 clocks after the rx_i falling edge (2 sync stages + edge register); busy rises on that clock.
- rx_done rises 1 clock after the tick that completes the stop-bit vote. That is ≈ (start edge) + 3 + 16*(br_div+1)*(N_bits-1) + 10*(br_div+1) clocks, where N_bits includes start, data, parity and stop.
- br_div=0: tick every clock, which is legal.
- br_div=650 at 100 MHz gives ≈9600 baud.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present; frame has one parity bit; parity_err is driven as above.
- Macro not defined: no PARITY state; DATA goes to STOP; parity_err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - OS_RATE=16
  - VOTE_T0=7, VOTE_T1=8, VOTE_T2=9
  - LAST_TICK=15
- Sub-module uart_baud_tick: divisor latch, tick counter, clear input and tick output. It is reusable by the transmitter.

## Test plan
All scenarios use br_div=3 (64 clocks/bit) and a parity-enabled build unless noted.
- Valid frame 0xA5 with parity 0 and stop 1 -> a single rx_done pulse, dout=0xA5, parity_err=0, frame_err=0, busy low after.
- Glitch: rx_i low for 20 clocks then high -> no rx_done, busy returns to 0, dout unchanged.
- Frame 0x03 with parity bit 1 -> rx_done, dout=0x03, parity_err=1, frame_err=0. Next clean 0x00 frame clears parity_err.
- Frame 0x5A with stop bit 0, line held low 200 clocks then high, then frame 0x3C:
  - first rx_done gives frame_err=1;
  - exactly one further rx_done gives dout=0x3C with both flags 0.
- Back-to-back 0x11 then 0x22 with no idle gap -> two rx_done pulses with dout 0x11 then 0x22.
- rst pulled low during data bit 4 -> all outputs 0 immediately. After release, frame 0x7E is received correctly.
- Build without UART_RX_PARITY_EN: 10-bit frame 0xC3 -> dout=0xC3, parity_err stays 0.
